// File: rtl/logic_alu_pipe.sv
// rtl/logic_alu_pipe.sv - two-stage pipelined AND/OR/XOR/ANDN unit with Y86 condition codes
module logic_alu_pipe #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic [TAG_W-1:0] out_tag
);
    logic             s1_valid_q, s1_valid_d;
    logic [1:0]       s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zf_q, s2_zf_d;
    logic             s2_sf_q, s2_sf_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] f_res;

    always_comb begin
        case (s1_op_q)
            2'b00:   f_res = s1_a_q & s1_b_q;
            2'b01:   f_res = s1_a_q | s1_b_q;
            2'b10:   f_res = s1_a_q ^ s1_b_q;
            default: f_res = s1_a_q & ~s1_b_q;
        endcase
    end

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;

        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_zf_d    = s2_zf_q;
        s2_sf_d    = s2_sf_q;
        s2_tag_d   = s2_tag_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_op_d  = in_op;
                s1_a_d   = in_a;
                s1_b_d   = in_b;
                s1_tag_d = in_tag;
            end
        end

        // Bubbles leave S2 data untouched so idle outputs keep their last (or reset) value.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = f_res;
                s2_zf_d  = (f_res == '0);
                s2_sf_d  = f_res[WIDTH-1];
                s2_tag_d = s1_tag_q;
            end
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_zf_q    <= 1'b0;
            s2_sf_q    <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_zf_q    <= s2_zf_d;
            s2_sf_q    <= s2_sf_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign in_ready  = s1_adv && !flush && !rst;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_zf    = s2_zf_q;
    assign out_sf    = s2_sf_q;
    assign out_of    = 1'b0;
    assign out_tag   = s2_tag_q;
endmodule

// File: tb/tb_logic_alu_pipe.sv
// tb/tb_logic_alu_pipe.sv - self-checking bench for logic_alu_pipe at WIDTH 8, 32 and 64
module tb_logic_alu_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  in_op;
    logic [63:0] a64, b64;
    logic [3:0]  in_tag;

    logic        ir8, ir32, ir64, ov8, ov32, ov64;
    logic [7:0]  res8;
    logic [31:0] res32;
    logic [63:0] res64;
    logic        zf8, zf32, zf64, sf8, sf32, sf64, of8, of32, of64;
    logic [3:0]  tag8, tag32, tag64;

    logic_alu_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir8),
        .in_op(in_op), .in_a(a64[7:0]), .in_b(b64[7:0]), .in_tag(in_tag),
        .out_valid(ov8), .out_ready(out_ready), .out_res(res8), .out_zf(zf8),
        .out_sf(sf8), .out_of(of8), .out_tag(tag8));

    logic_alu_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
        .in_op(in_op), .in_a(a64[31:0]), .in_b(b64[31:0]), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_res(res32), .out_zf(zf32),
        .out_sf(sf32), .out_of(of32), .out_tag(tag32));

    logic_alu_pipe #(.WIDTH(64), .TAG_W(4)) u64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
        .in_op(in_op), .in_a(a64), .in_b(b64), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready), .out_res(res64), .out_zf(zf64),
        .out_sf(sf64), .out_of(of64), .out_tag(tag64));

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  tag;
        int          acc;
    } op_t;

    typedef struct {
        logic [63:0] r64;
        logic [31:0] r32;
        logic [7:0]  r8;
        logic [3:0]  tag;
        logic        zf32, sf32, sf8, sf64;
        int          lat;
    } res_t;

    op_t  mq[$];
    res_t rlog[$];
    int   nchecks = 0;
    int   nerr = 0;
    int   cyc = 0;
    logic hold_q = 1'b0;
    logic [31:0] hold_res;
    logic [3:0]  hold_tag;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    // Reference model: FIFO of accepted ops; the oldest must show two cycles after acceptance.
    always @(negedge clk) begin
        logic        exp_ir, exp_ov;
        logic [63:0] r;
        res_t        e;
        if (rst) begin
            chk("rst_in_ready", {ir8, ir32, ir64}, 64'd0);
            chk("rst_out_valid", {ov8, ov32, ov64}, 64'd0);
            mq.delete();
            hold_q = 1'b0;
        end else begin
            exp_ir = !flush && (mq.size() < 2 || out_ready);
            chk("in_ready", {ir8, ir32, ir64}, {61'd0, {3{exp_ir}}});
            exp_ov = mq.size() > 0 && (cyc - mq[0].acc) >= 2;
            chk("out_valid", {ov8, ov32, ov64}, {61'd0, {3{exp_ov}}});
            if (ov32 && mq.size() > 0) begin
                r = alu(mq[0].op, mq[0].a, mq[0].b);
                chk("res32", res32, r[31:0]);
                chk("zf32", zf32, r[31:0] == 0);
                chk("sf32", sf32, r[31]);
                chk("res8", res8, r[7:0]);
                chk("zf8", zf8, r[7:0] == 0);
                chk("sf8", sf8, r[7]);
                chk("res64", res64, r);
                chk("zf64", zf64, r == 0);
                chk("sf64", sf64, r[63]);
                chk("of", {of8, of32, of64}, 64'd0);
                chk("tag", {tag8, tag32, tag64}, {52'd0, {3{mq[0].tag}}});
                if (hold_q) begin
                    chk("stall_res_stable", res32, hold_res);
                    chk("stall_tag_stable", tag32, hold_tag);
                end
            end
            hold_q   = ov32 && !out_ready && !flush;
            hold_res = res32;
            hold_tag = tag32;
            if (flush) begin
                mq.delete();
            end else begin
                if (ov32 && out_ready && mq.size() > 0) begin
                    e.r64 = res64; e.r32 = res32; e.r8 = res8; e.tag = tag32;
                    e.zf32 = zf32; e.sf32 = sf32; e.sf8 = sf8; e.sf64 = sf64;
                    e.lat = cyc - mq[0].acc;
                    rlog.push_back(e);
                    void'(mq.pop_front());
                end
                if (in_valid && ir32)
                    mq.push_back('{op: in_op, a: a64, b: b64, tag: in_tag, acc: cyc});
            end
        end
        cyc++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        logic acc;
        int   n;
        in_valid = 1'b1; in_op = op; a64 = a; b64 = b; in_tag = tag;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = ir32;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            nchecks++;
            nerr++;
            $display("FAIL send_timeout: tag %0d not accepted within 50 cycles", tag);
        end
        in_valid = 1'b0;
    endtask

    int          base;
    logic        lowseen;
    logic [31:0] tt_exp [4];

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_op = 2'd2; a64 = '1; b64 = '0; in_tag = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", ov32, 0);
        chk("reset_out_res", res64, 0);
        chk("reset_flags", {zf32, sf32, of32}, 0);
        chk("reset_out_tag", tag32, 0);
        chk("reset_in_ready", ir32, 1);
        @(posedge clk);
        #1;

        // Truth table
        tt_exp = '{32'h8, 32'hF, 32'h7, 32'h3};
        base = rlog.size();
        for (int i = 0; i < 4; i++) send(i[1:0], 64'hB, 64'hC, 4'(i + 1));
        idle(4);
        chk("tt_count", rlog.size() - base, 4);
        for (int i = 0; i < 4 && base + i < rlog.size(); i++) begin
            chk("tt_res", rlog[base+i].r32, tt_exp[i]);
            chk("tt_tag", rlog[base+i].tag, i + 1);
            chk("tt_latency", rlog[base+i].lat, 2);
        end

        // Flags
        base = rlog.size();
        send(2'd2, 64'h9, 64'h9, 4'd5);
        send(2'd2, 64'hFFFF_FFFE, 64'hD, 4'd6);
        idle(4);
        chk("flags_count", rlog.size() - base, 2);
        if (rlog.size() >= base + 2) begin
            chk("flags_zero_res", rlog[base].r32, 32'h0);
            chk("flags_zero_zf_sf", {rlog[base].zf32, rlog[base].sf32}, 2'b10);
            chk("flags_neg_res", rlog[base+1].r32, 32'hFFFF_FFF3);
            chk("flags_neg_zf_sf", {rlog[base+1].zf32, rlog[base+1].sf32}, 2'b01);
        end

        // Backpressure
        base = rlog.size();
        lowseen = 1'b0;
        fork
            for (int i = 0; i < 6; i++)
                send(2'(i % 4), 64'h0123_4567_89AB_CDEF + 64'(i * 17), 64'hF0F0_0FF0_3C3C_A5A5, 4'(i + 8));
            begin
                out_ready = 1'b1;
                idle(2);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (!ir32) lowseen = 1'b1;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(6);
        chk("bp_in_ready_dropped", lowseen, 1);
        chk("bp_count", rlog.size() - base, 6);
        for (int i = 0; i < 6 && base + i < rlog.size(); i++)
            chk("bp_order", rlog[base+i].tag, i + 8);

        // Flush
        out_ready = 1'b0;
        base = rlog.size();
        send(2'd0, 64'h33, 64'h0F, 4'd7);
        send(2'd1, 64'h30, 64'h03, 4'd8);
        flush = 1'b1; in_valid = 1'b1; in_op = 2'd2; a64 = 64'h1; b64 = 64'h2; in_tag = 4'd9;
        @(negedge clk);
        chk("flush_in_ready", ir32, 0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_out_valid", ov32, 0);
        end
        @(posedge clk);
        #1;
        chk("flush_squashed", rlog.size() - base, 0);
        out_ready = 1'b1;
        send(2'd2, 64'hF0, 64'h0F, 4'd10);
        idle(4);
        chk("post_flush_count", rlog.size() - base, 1);
        if (rlog.size() > base) begin
            chk("post_flush_tag", rlog[base].tag, 10);
            chk("post_flush_res", rlog[base].r32, 32'hFF);
            chk("post_flush_latency", rlog[base].lat, 2);
        end

        // Width sweep
        base = rlog.size();
        send(2'd2, '1, 64'h5555_5555_5555_5555, 4'd1);
        send(2'd0, '1, 64'h5555_5555_5555_5555, 4'd2);
        idle(4);
        chk("sweep_count", rlog.size() - base, 2);
        if (rlog.size() >= base + 2) begin
            chk("sweep_xor8", {rlog[base].sf8, rlog[base].r8}, 9'h1AA);
            chk("sweep_xor32", rlog[base].r32, 32'hAAAA_AAAA);
            chk("sweep_xor64", {rlog[base].sf64, rlog[base].r64}, {1'b1, 64'hAAAA_AAAA_AAAA_AAAA});
            chk("sweep_and8", {rlog[base+1].sf8, rlog[base+1].r8}, 9'h055);
            chk("sweep_and64", {rlog[base+1].sf64, rlog[base+1].r64}, {1'b0, 64'h5555_5555_5555_5555});
        end

        chk("model_drained", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule

// File: doc/logic_alu_pipe.md
# logic_alu_pipe

Parametrised, pipelined logic unit for the Y86-64 execute stage. It generalises the fixed 32-bit combinational XOR to a configurable-width AND/OR/XOR/ANDN unit, and adds the Y86 condition codes (ZF, SF, OF). Operands travel through a two-stage register pipeline with a valid/ready handshake, a tag passthrough and a synchronous flush for branch-mispredict squashing. It sits between decode/operand-select and the E/M pipeline register, alongside the adder.

## Interface
- WIDTH, 64: operand and result width in bits; legal range is 8 or greater.
- TAG_W, 4: width of the instruction tag carried alongside each operation.
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of every in-flight operation.
- in_valid  in  1  an operation is presented on the inputs.
- in_ready  out  1  the unit accepts the presented operation this cycle.
- in_op  in  2  operation select: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAG_W  instruction tag.
- out_valid  out  1  result is valid.
- out_ready  in  1  the consumer takes the result this cycle.
- out_res  out  WIDTH  result.
- out_zf  out  1  zero flag: out_res == 0.
- out_sf  out  1  sign flag: out_res[WIDTH-1].
- out_of  out  1  overflow flag; always 0 for logic operations.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Stage 1 (S1) holds the accepted op, A, B and tag, plus s1_valid.
- Stage 2 (S2) holds the computed result, flags and tag, plus s2_valid. The out_* ports are driven directly from S2 registers, with no combinational path from inputs to outputs.
- s2_adv = !s2_valid | out_ready.
- s1_adv = !s1_valid | s2_adv.
- in_ready = s1_adv. This is combinational from out_ready and the valid bits only, and never depends on in_valid.
- Accept: in_valid & in_ready loads S1 and sets s1_valid. If S1 can advance but in_valid is low, s1_valid clears.
- S1 to S2: when s2_adv is high, S2 loads f(op, A, B) and its flags, and s2_valid <= s1_valid. When s2_adv is low, S2 holds every field unchanged (stall).
- Result arithmetic is pure bitwise over WIDTH bits: no carry, no sign extension.
- Flags are computed from the full-width result. OF is forced to 0.
- Flush has priority over accept and advance. On a flush cycle, s1_valid and s2_valid clear and in_ready is forced to 0, so an operation offered in the same cycle is not accepted. Data registers keep their contents and are don't-care.
- rst has the highest priority and has the same effect as flush. It additionally zeroes all data registers.
- Throughput is one operation per cycle with no bubbles while out_ready stays high.
- Ordering is strictly FIFO. No operation is dropped or duplicated except by flush or rst.

## Timing
- Reset values: out_valid=0, out_res=0, out_zf=0, out_sf=0, out_of=0, out_tag=0. in_ready=1 in the first cycle after reset is released, and 0 while rst is high.
- Latency: an operation accepted at edge N has out_valid=1 after edge N+1 (two registers). The consumer can take it at edge N+2 at the earliest.
- Backpressure: with out_ready low, S2 holds and S1 holds. in_ready drops in the cycle after S1 fills, so the unit holds at most 2 operations.
- Release: when out_ready rises with both stages full, S2 takes S1 and S1 takes the new input at the same edge.
- Output stability: while out_valid=1 and out_ready=0, every out_* port stays constant.
- Mid-operation reset or flush: out_valid=0 from the next cycle. The squashed results never appear on the outputs.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 -> out_valid stays 0 and in_ready=0 during rst. After release, all outputs read 0 and in_ready=1.
- Truth table, WIDTH=32, A=0x0000000B, B=0x0000000C, out_ready=1:
  - AND -> 0x00000008.
  - OR -> 0x0000000F.
  - XOR -> 0x00000007.
  - ANDN -> 0x00000003.
  - Each appears exactly 2 edges after acceptance, with the tags 1, 2, 3, 4 in order.
- Flags: XOR with A=B=0x9 -> res=0, zf=1, sf=0. XOR with A=-2 (0xFFFFFFFE), B=13 (0x0000000D) -> res=0xFFFFFFF3, zf=0, sf=1. of=0 in every case.
- Backpressure: stream 6 back-to-back ops and hold out_ready=0 for cycles 3-7 -> in_ready goes low once 2 ops are held, outputs are stable while stalled, and all 6 results emerge in order with none lost.
- Flush: accept 2 ops, then assert flush together with a third in_valid -> out_valid stays 0, the third op is not accepted (in_ready=0), and the next op after flush appears after the normal 2-cycle latency.
- Width sweep: rerun the truth-table test at WIDTH=8 and WIDTH=64 with A=all-ones and B=0x5...5 -> XOR gives 0xA...A with sf=1, and AND gives 0x5...5 with sf=0.
